// File: rtl/note_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// note_sequencer_pkg
// Shared definitions for the melody sequencer: FSM state encoding, the
// end-of-melody marker value and a helper that decodes the "playing" states.
// No ports (package).
// -----------------------------------------------------------------------------
package note_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    LOAD   = 3'd3,
    HOLD   = 3'd4,
    PAUSED = 3'd5
  } seq_state_t;

  // A ROM entry whose length field equals this value marks the end of the melody.
  localparam int END_LEN = 0;

  // PAUSED is deliberately excluded: the note sustains, but playback is frozen.
  function automatic logic is_playing(input seq_state_t s);
    return (s == FETCH) || (s == WAIT) || (s == LOAD) || (s == HOLD);
  endfunction

endpackage

// File: rtl/note_sequencer_tempo_divider.sv
// -----------------------------------------------------------------------------
// note_sequencer_tempo_divider
// Free-running tempo counter, 0..TICK_DIV-1, with synchronous clear and
// count enable. tick is high during the enabled cycle in which the counter
// sits at TICK_DIV-1; the counter wraps to 0 on that same edge.
//
// Ports:
//   clk   in   system clock, rising edge
//   r_n   in   asynchronous active-low reset (counter -> 0)
//   clr   in   synchronous clear (counter -> 0), wins over en
//   en    in   count enable; when low the counter holds its value
//   tick  out  one-cycle tempo tick
// -----------------------------------------------------------------------------
module note_sequencer_tempo_divider #(
  parameter int TICK_DIV = 12500000
) (
  input  logic clk,
  input  logic r_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
// Walks a melody ROM of {note, len} entries. Each entry is fetched (address
// out, one cycle of ROM latency, sample), the note is handed to the downstream
// note register with a one-cycle load strobe and then held for len tempo
// ticks. A len of END_LEN ends the melody (or rewinds when loop_en is set).
// Controls are evaluated every cycle with priority stop > pause > play.
//
// Strobe semantics towards the downstream register: note_en and note_clr are
// single-cycle, mutually exclusive strobes with no back-pressure; note_d is
// valid whenever note_en is high and stays stable until the next load.
//
// Ports:
//   clk        in   system clock, rising edge
//   r_n        in   asynchronous active-low reset
//   play       in   level; start from IDLE or resume from PAUSED
//   pause      in   level; freeze playback while holding a note
//   stop       in   level; abort playback and rewind to address 0
//   loop_en    in   rewind to address 0 instead of finishing at the end marker
//   rom_addr   out  registered melody ROM address
//   rom_data   in   {note, len}; valid one cycle after rom_addr
//   note_d     out  note code to the downstream register d
//   note_en    out  one-cycle load strobe to the downstream register en
//   note_clr   out  one-cycle clear to the downstream register r (silence)
//   playing    out  high in FETCH/WAIT/LOAD/HOLD
//   done       out  one-cycle pulse on the end marker when loop_en=0
//   fsm_state  out  current FSM state (debug observation)
// -----------------------------------------------------------------------------
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 12500000,
  parameter int ADDR_W   = 6,
  parameter int NOTE_W   = 5,
  parameter int LEN_W    = 3
) (
  input  logic                      clk,
  input  logic                      r_n,
  input  logic                      play,
  input  logic                      pause,
  input  logic                      stop,
  input  logic                      loop_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [NOTE_W+LEN_W-1:0]   rom_data,
  output logic [NOTE_W-1:0]         note_d,
  output logic                      note_en,
  output logic                      note_clr,
  output logic                      playing,
  output logic                      done,
  output logic [2:0]                fsm_state
);

  seq_state_t        state, state_next;
  logic [ADDR_W-1:0] addr_next;
  logic [NOTE_W-1:0] note_next;
  logic [LEN_W-1:0]  dur, dur_next;
  logic              en_next, clr_next, done_next;
  logic              div_clr, div_en, tick;

  logic [NOTE_W-1:0] rom_note;
  logic [LEN_W-1:0]  rom_len;

  assign rom_note  = rom_data[NOTE_W+LEN_W-1:LEN_W];
  assign rom_len   = rom_data[LEN_W-1:0];
  assign fsm_state = state;

  // The divider only advances in HOLD cycles that are not about to leave HOLD
  // because of stop or pause, so a pause freezes the count at exactly the
  // value it had and resume continues from there.
  assign div_en = (state == HOLD) && !stop && !pause;

  note_sequencer_tempo_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tempo (
    .clk  (clk),
    .r_n  (r_n),
    .clr  (div_clr),
    .en   (div_en),
    .tick (tick)
  );

  always_comb begin
    state_next = state;
    addr_next  = rom_addr;
    note_next  = note_d;
    dur_next   = dur;
    en_next    = 1'b0;
    clr_next   = 1'b0;
    done_next  = 1'b0;
    div_clr    = 1'b0;

    if (stop && (state != IDLE)) begin
      // Abort wins over everything, including a load landing this cycle.
      state_next = IDLE;
      addr_next  = '0;
      clr_next   = 1'b1;
      div_clr    = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (play && !stop) begin
            state_next = FETCH;
            addr_next  = '0;
          end
        end
        FETCH: state_next = WAIT;
        WAIT:  state_next = LOAD;
        LOAD: begin
          if (rom_len == LEN_W'(END_LEN)) begin
            addr_next = '0;
            if (loop_en) begin
              state_next = FETCH;
            end else begin
              state_next = IDLE;
              done_next  = 1'b1;
              clr_next   = 1'b1;
            end
          end else begin
            note_next  = rom_note;
            en_next    = 1'b1;
            dur_next   = rom_len;
            div_clr    = 1'b1;
            state_next = HOLD;
          end
        end
        HOLD: begin
          if (pause) begin
            state_next = PAUSED;
          end else if (tick) begin
            dur_next = dur - 1'b1;
            if (dur == LEN_W'(1)) begin
              // Wraps modulo 2^ADDR_W; no end marker needed at the top.
              addr_next  = rom_addr + 1'b1;
              state_next = FETCH;
            end
          end
        end
        PAUSED: begin
          if (play && !pause) state_next = HOLD;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state    <= IDLE;
      rom_addr <= '0;
      note_d   <= '0;
      dur      <= '0;
      note_en  <= 1'b0;
      note_clr <= 1'b0;
      done     <= 1'b0;
      playing  <= 1'b0;
    end else begin
      state    <= state_next;
      rom_addr <= addr_next;
      note_d   <= note_next;
      dur      <= dur_next;
      note_en  <= en_next;
      note_clr <= clr_next;
      done     <= done_next;
      playing  <= is_playing(state_next);
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
// Directed bench for note_sequencer with TICK_DIV=4. Stimulus tasks push the
// hand-computed strobe events (cycle, en, clr, done, note, addr) into exp_q;
// a negedge monitor pops and compares whenever a strobe is seen.
// -----------------------------------------------------------------------------
module tb_note_sequencer;

  localparam int TICK_DIV = 4;
  localparam int ADDR_W   = 6;
  localparam int NOTE_W   = 5;
  localparam int LEN_W    = 3;
  localparam int W        = 30;  // {cyc16, en, clr, done, note5, addr6}

  logic clk = 1'b0;
  logic r_n = 1'b0;
  logic play = 1'b0, pause = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [ADDR_W-1:0]       rom_addr;
  logic [NOTE_W+LEN_W-1:0] rom_data = '0;
  logic [NOTE_W-1:0]       note_d;
  logic note_en, note_clr, playing, done;
  logic [2:0] fsm_state;

  logic [NOTE_W+LEN_W-1:0] rom [64];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_act, mon_exp;

  note_sequencer #(
    .TICK_DIV (TICK_DIV),
    .ADDR_W   (ADDR_W),
    .NOTE_W   (NOTE_W),
    .LEN_W    (LEN_W)
  ) dut (
    .clk       (clk),
    .r_n       (r_n),
    .play      (play),
    .pause     (pause),
    .stop      (stop),
    .loop_en   (loop_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note_d    (note_d),
    .note_en   (note_en),
    .note_clr  (note_clr),
    .playing   (playing),
    .done      (done),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset / ROM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rom_data <= rom[rom_addr];
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (note_en || note_clr || done) begin
      mon_act = {16'(cyc), note_en, note_clr, done, note_d, rom_addr};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got cyc=%0d en=%b clr=%b done=%b note=%0d addr=%0d, required no event",
                 cyc, note_en, note_clr, done, note_d, rom_addr);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_err++;
          $display("FAIL event: got cyc=%0d en=%b clr=%b done=%b note=%0d addr=%0d, required cyc=%0d en=%b clr=%b done=%b note=%0d addr=%0d",
                   mon_act[29:14], mon_act[13], mon_act[12], mon_act[11], mon_act[10:6], mon_act[5:0],
                   mon_exp[29:14], mon_exp[13], mon_exp[12], mon_exp[11], mon_exp[10:6], mon_exp[5:0]);
        end
      end
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic push_ev(input int c, input bit en, input bit clr, input bit dn,
                         input logic [4:0] n, input logic [5:0] a);
    exp_q.push_back({16'(c), en, clr, dn, n, a});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; returns the cycle at whose edge play is sampled.
  task automatic start_play(output int tp);
    tp = cyc + 1;
    play = 1'b1;
    @(negedge clk);
    play = 1'b0;
  endtask

  task automatic load_basic(input logic [2:0] len0);
    for (int i = 0; i < 64; i++) rom[i] = '0;
    rom[0] = {5'd7, len0};
    rom[1] = {5'd9, 3'd1};
    rom[2] = {5'd31, 3'd0};
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout required completion");
    n_err++;
    summary();
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    int tp;
    load_basic(3'd2);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {rom_addr, note_d, note_en, note_clr, done, playing, fsm_state}, 32'd0);
    r_n = 1'b1;
    @(negedge clk);

    // Basic play: {7,2},{9,1},{end}
    start_play(tp);
    push_ev(tp + 3,  1, 0, 0, 5'd7, 6'd0);
    push_ev(tp + 14, 1, 0, 0, 5'd9, 6'd1);
    push_ev(tp + 21, 0, 1, 1, 5'd9, 6'd0);
    wait_cyc(tp + 8);
    check("playing_in_hold", playing, 32'd1);
    check("note_held", note_d, 32'd7);
    wait_cyc(tp + 25);
    check("idle_after_done", fsm_state, 32'd0);
    check("addr_after_done", rom_addr, 32'd0);
    check("playing_after_done", playing, 32'd0);

    // Loop: end marker rewinds, no done; stop during second pass of note 9
    loop_en = 1'b1;
    start_play(tp);
    push_ev(tp + 3,  1, 0, 0, 5'd7, 6'd0);
    push_ev(tp + 14, 1, 0, 0, 5'd9, 6'd1);
    push_ev(tp + 24, 1, 0, 0, 5'd7, 6'd0);
    push_ev(tp + 35, 1, 0, 0, 5'd9, 6'd1);
    push_ev(tp + 37, 0, 1, 0, 5'd9, 6'd0);
    wait_cyc(tp + 36);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    loop_en = 1'b0;
    check("loop_stop_state", fsm_state, 32'd0);
    check("loop_stop_addr", rom_addr, 32'd0);
    repeat (3) @(negedge clk);

    // Pause/resume on a len=3 note
    load_basic(3'd3);
    start_play(tp);
    push_ev(tp + 3,  1, 0, 0, 5'd7, 6'd0);
    push_ev(tp + 39, 1, 0, 0, 5'd9, 6'd1);
    push_ev(tp + 46, 0, 1, 1, 5'd9, 6'd0);
    wait_cyc(tp + 4);
    pause = 1'b1;
    wait_cyc(tp + 15);
    check("paused_state", fsm_state, 32'd5);
    check("paused_note", note_d, 32'd7);
    check("paused_not_playing", playing, 32'd0);
    wait_cyc(tp + 24);
    pause = 1'b0;
    play = 1'b1;
    @(negedge clk);
    play = 1'b0;
    check("resumed_state", fsm_state, 32'd4);
    wait_cyc(tp + 50);
    check("idle_after_pause_run", fsm_state, 32'd0);

    // Stop together with play in HOLD, then restart from address 0
    load_basic(3'd2);
    start_play(tp);
    push_ev(tp + 3, 1, 0, 0, 5'd7, 6'd0);
    wait_cyc(tp + 5);
    push_ev(tp + 6, 0, 1, 0, 5'd7, 6'd0);
    stop = 1'b1;
    play = 1'b1;
    @(negedge clk);
    check("stop_state", fsm_state, 32'd0);
    check("stop_addr", rom_addr, 32'd0);
    @(negedge clk);
    check("stop_blocks_play", fsm_state, 32'd0);
    stop = 1'b0;
    play = 1'b0;
    @(negedge clk);
    start_play(tp);
    push_ev(tp + 3,  1, 0, 0, 5'd7, 6'd0);
    push_ev(tp + 14, 1, 0, 0, 5'd9, 6'd1);
    push_ev(tp + 21, 0, 1, 1, 5'd9, 6'd0);
    wait_cyc(tp + 25);

    // Address wrap: every entry len=1, note = addr[4:0]
    for (int i = 0; i < 64; i++) rom[i] = {5'(i), 3'd1};
    start_play(tp);
    for (int k = 0; k < 66; k++)
      push_ev(tp + 3 + 7 * k, 1, 0, 0, 5'(k % 32), 6'(k % 64));
    wait_cyc(tp + 459);
    push_ev(tp + 460, 0, 1, 0, 5'd1, 6'd0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("wrap_stop_addr", rom_addr, 32'd0);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-HOLD, between clock edges
    load_basic(3'd2);
    start_play(tp);
    push_ev(tp + 3, 1, 0, 0, 5'd7, 6'd0);
    wait_cyc(tp + 5);
    check("pre_reset_note", note_d, 32'd7);
    #2;
    r_n = 1'b0;
    #1;
    check("async_reset_outputs", {rom_addr, note_d, note_en, note_clr, done, playing, fsm_state}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    r_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_after_reset", fsm_state, 32'd0);
    check("silent_after_reset", {note_d, playing}, 32'd0);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    summary();
    $finish;
  end

endmodule
